// File: rtl/eth_tx_pkg.sv
// ============================================================================
// eth_tx_pkg : shared states and constants for the Ethernet transmit framer
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        PAD  = 3'd4,
        FCS  = 3'd5,
        IFG  = 3'd6
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_B = 8'h55;
    localparam logic [7:0]  SFD_B      = 8'hD5;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam int unsigned PRE_BYTES  = 7;

endpackage

`default_nettype wire

// File: rtl/eth_tx_framer_crc32.sv
// ============================================================================
// eth_crc32 : byte-wide reflected CRC-32 register (LSB-first, 8 steps/cycle)
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module eth_crc32
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] step;

    always_comb begin
        step = crc_q;
        for (int i = 0; i < 8; i++) begin
            step = (step[0] ^ d[i]) ? ((step >> 1) ^ CRC_POLY) : (step >> 1);
        end
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/eth_tx_framer.sv
// ============================================================================
// eth_tx_framer : preamble/SFD/data/pad/FCS/IFG byte framer at half txclk rate
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module eth_tx_framer
    import eth_tx_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int MIN_LEN   = 60,
    parameter int MAX_LEN   = 1514,
    parameter int IFG_BYTES = 12
) (
    input  logic              txclk_i,
    input  logic              rst,
    input  logic              start_i,
    input  logic [10:0]       len_i,
    input  logic              nocrc_i,
    input  logic              nopad_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_dat_i,
    output logic [7:0]        dat_o,
    output logic              txen_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    tx_state_e         state_q, state_d;
    logic              ph_q, ph_d;
    logic [10:0]       len_q, len_d;
    logic              nocrc_q, nocrc_d;
    logic              nopad_q, nopad_d;
    logic [10:0]       byte_cnt_q, byte_cnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        dat_q, dat_d;
    logic              txen_q, txen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              crc_init;
    logic              crc_en;
    logic [7:0]        crc_byte;
    logic [31:0]       crc;
    logic              len_ok;
    logic              last_data;
    logic              need_pad;

    eth_crc32 u_crc (
        .clk  (txclk_i),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .d    (crc_byte),
        .crc  (crc)
    );

    assign len_ok    = (len_i != 11'd0) && (len_i <= 11'(MAX_LEN));
    assign last_data = (byte_cnt_q == len_q - 11'd1);
    assign need_pad  = !nopad_q && (len_q < 11'(MIN_LEN));

    // Every byte-stream update is gated by ph_q, so each byte is held two cycles.
    always_comb begin
        state_d    = state_q;
        ph_d       = ~ph_q;
        len_d      = len_q;
        nocrc_d    = nocrc_q;
        nopad_d    = nopad_q;
        byte_cnt_d = byte_cnt_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        dat_d      = dat_q;
        txen_d     = txen_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        crc_byte   = 8'h00;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        state_d    = PRE;
                        len_d      = len_i;
                        nocrc_d    = nocrc_i;
                        nopad_d    = nopad_i;
                        byte_cnt_d = 11'd0;
                        cnt_d      = 4'd0;
                        rd_addr_d  = '0;
                        busy_d     = 1'b1;
                        crc_init   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                if (ph_q) begin
                    dat_d  = PREAMBLE_B;
                    txen_d = 1'b1;
                    if (cnt_q == 4'(PRE_BYTES - 1)) begin
                        cnt_d   = 4'd0;
                        state_d = SFD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            SFD: begin
                if (ph_q) begin
                    dat_d   = SFD_B;
                    txen_d  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ph_q) begin
                    dat_d      = rd_dat_i;
                    txen_d     = 1'b1;
                    crc_en     = 1'b1;
                    crc_byte   = rd_dat_i;
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    // Address stays on the last byte so it never runs past the frame.
                    if (last_data) begin
                        state_d = need_pad ? PAD : (nocrc_q ? IFG : FCS);
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            PAD: begin
                if (ph_q) begin
                    dat_d      = 8'h00;
                    txen_d     = 1'b1;
                    crc_en     = 1'b1;
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    if (byte_cnt_q == 11'(MIN_LEN - 1)) begin
                        state_d = nocrc_q ? IFG : FCS;
                    end
                end
            end
            FCS: begin
                if (ph_q) begin
                    dat_d  = ~crc[{cnt_q[1:0], 3'b000} +: 8];
                    txen_d = 1'b1;
                    if (cnt_q == 4'd3) begin
                        cnt_d   = 4'd0;
                        state_d = IFG;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            IFG: begin
                // First tick drops txen; the gap then spans IFG_BYTES full byte times.
                if (ph_q) begin
                    dat_d  = 8'h00;
                    txen_d = 1'b0;
                    if (cnt_q == 4'(IFG_BYTES)) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge txclk_i or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ph_q       <= 1'b0;
            len_q      <= 11'd0;
            nocrc_q    <= 1'b0;
            nopad_q    <= 1'b0;
            byte_cnt_q <= 11'd0;
            cnt_q      <= 4'd0;
            rd_addr_q  <= '0;
            dat_q      <= 8'h00;
            txen_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            len_q      <= len_d;
            nocrc_q    <= nocrc_d;
            nopad_q    <= nopad_d;
            byte_cnt_q <= byte_cnt_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            dat_q      <= dat_d;
            txen_q     <= txen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rd_addr_o = rd_addr_q;
    assign dat_o     = dat_q;
    assign txen_o    = txen_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

`default_nettype wire
